// File: rtl/mem_stage_vec.sv
// mem_stage_vec: scalar/vector data-memory stage with multi-cycle beats and MMIO LED/HEX registers.
module mem_stage_vec #(
  parameter int         DATA_WIDTH  = 16,
  parameter int         ADDR_WIDTH  = 10,
  parameter int         NLANES      = 4,
  parameter int         MEM_LATENCY = 2,
  parameter logic [9:0] ADDR_LEDR   = 10'h3FC,
  parameter logic [9:0] ADDR_LEDG   = 10'h3FD,
  parameter logic [9:0] ADDR_HEX    = 10'h3FE
) (
  input  logic                         I_CLOCK,
  input  logic                         I_LOCK,
  input  logic                         I_Valid,
  input  logic [2:0]                   I_Op,
  input  logic [3:0]                   I_DestRegIdx,
  input  logic [DATA_WIDTH-1:0]        I_DestValue,
  input  logic [ADDR_WIDTH-1:0]        I_MARValue,
  input  logic [DATA_WIDTH-1:0]        I_MDRValue,
  input  logic [NLANES*DATA_WIDTH-1:0] I_VecStoreValue,
  output logic                         O_Stall,
  output logic                         O_Valid,
  output logic [3:0]                   O_DestRegIdx,
  output logic [DATA_WIDTH-1:0]        O_DestValue,
  output logic [NLANES*DATA_WIDTH-1:0] O_VecValue,
  output logic [9:0]                   O_LEDR,
  output logic [7:0]                   O_LEDG,
  output logic [15:0]                  O_HexOut
);
  localparam int WW    = ADDR_WIDTH - 1;
  localparam int DEPTH = 1 << WW;
  localparam int VW    = NLANES * DATA_WIDTH;
  localparam int LW    = NLANES > 1 ? $clog2(NLANES) : 1;
  localparam int BW    = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY) : 1;
  localparam logic [2:0] OP_LDW = 3'd1, OP_STW = 3'd2, OP_VLDW = 3'd3, OP_VSTW = 3'd4;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t                state_q, state_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [LW-1:0]         lane_q, lane_d;
  logic [2:0]            op_q, op_d;
  logic [3:0]            tag_q, tag_d, otag_q, otag_d;
  logic [ADDR_WIDTH-1:0] mar_q, mar_d;
  logic [DATA_WIDTH-1:0] mdr_q, mdr_d, oval_q, oval_d;
  logic [VW-1:0]         vst_q, vst_d, vbuf_q, vbuf_d, ovec_q, ovec_d;
  logic                  valid_q, valid_d, stall_q, stall_d;
  logic [9:0]            ledr_q, ledr_d;
  logic [7:0]            ledg_q, ledg_d;
  logic [15:0]           hex_q, hex_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [WW-1:0]         waddr;
  logic [9:0]            mar10;
  logic [DATA_WIDTH-1:0] rdata, sdata, ldata;
  logic [VW-1:0]         vnext;
  logic                  is_vec, is_store, is_mmio, last_beat, last_lane, we, req_mem;
  // Vector lanes walk consecutive words and wrap naturally at the top of the array.
  assign waddr     = mar_q[ADDR_WIDTH-1:1] + WW'(lane_q);
  assign mar10     = mar_q[9:0];
  assign is_vec    = op_q == OP_VLDW || op_q == OP_VSTW;
  assign is_store  = op_q == OP_STW || op_q == OP_VSTW;
  assign is_mmio   = !is_vec && (mar10 == ADDR_LEDR || mar10 == ADDR_LEDG || mar10 == ADDR_HEX);
  assign last_beat = beat_q == BW'(MEM_LATENCY - 1);
  assign last_lane = !is_vec || lane_q == LW'(NLANES - 1);
  assign we        = state_q == BUSY && last_beat && is_store && !is_mmio;
  assign req_mem   = I_Op inside {OP_LDW, OP_STW, OP_VLDW, OP_VSTW};
  assign rdata     = mem[waddr];
  assign sdata     = is_vec ? vst_q[lane_q*DATA_WIDTH +: DATA_WIDTH] : mdr_q;
  assign ldata     = !is_mmio ? rdata :
                     mar10 == ADDR_LEDR ? DATA_WIDTH'(ledr_q) :
                     mar10 == ADDR_LEDG ? DATA_WIDTH'(ledg_q) : DATA_WIDTH'(hex_q);
  always_comb begin
    vnext = vbuf_q;
    vnext[lane_q*DATA_WIDTH +: DATA_WIDTH] = rdata;
  end
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    lane_d  = lane_q;
    op_d    = op_q;
    tag_d   = tag_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    vst_d   = vst_q;
    vbuf_d  = vbuf_q;
    valid_d = 1'b0;
    stall_d = stall_q;
    otag_d  = otag_q;
    oval_d  = oval_q;
    ovec_d  = ovec_q;
    ledr_d  = ledr_q;
    ledg_d  = ledg_q;
    hex_d   = hex_q;
    if (state_q == BUSY) begin
      beat_d = last_beat ? '0 : beat_q + 1'b1;
      if (last_beat) begin
        vbuf_d = vnext;
        lane_d = last_lane ? '0 : lane_q + 1'b1;
        if (last_lane) begin
          state_d = DONE;
          valid_d = 1'b1;
          stall_d = 1'b0;
          otag_d  = tag_q;
          oval_d  = op_q == OP_LDW ? ldata : oval_q;
          ovec_d  = op_q == OP_VLDW ? vnext : ovec_q;
          ledr_d  = op_q == OP_STW && mar10 == ADDR_LEDR ? 10'(mdr_q) : ledr_q;
          ledg_d  = op_q == OP_STW && mar10 == ADDR_LEDG ? 8'(mdr_q) : ledg_q;
          hex_d   = op_q == OP_STW && mar10 == ADDR_HEX ? 16'(mdr_q) : hex_q;
        end
      end
    end else begin
      // DONE behaves as IDLE for acceptance so throughput is latency+1 edges.
      state_d = IDLE;
      if (I_Valid && req_mem) begin
        state_d = BUSY;
        stall_d = 1'b1;
        beat_d  = '0;
        lane_d  = '0;
        op_d    = I_Op;
        tag_d   = I_DestRegIdx;
        mar_d   = I_MARValue;
        mdr_d   = I_MDRValue;
        vst_d   = I_VecStoreValue;
      end else if (I_Valid) begin
        valid_d = 1'b1;
        otag_d  = I_DestRegIdx;
        oval_d  = I_DestValue;
      end
    end
  end
  always_ff @(negedge I_CLOCK or negedge I_LOCK) begin
    if (!I_LOCK) begin
      state_q <= IDLE;
      beat_q  <= '0;
      lane_q  <= '0;
      op_q    <= '0;
      tag_q   <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
      vst_q   <= '0;
      vbuf_q  <= '0;
      valid_q <= 1'b0;
      stall_q <= 1'b0;
      otag_q  <= '0;
      oval_q  <= '0;
      ovec_q  <= '0;
      ledr_q  <= 10'h3FF;
      ledg_q  <= 8'hFF;
      hex_q   <= 16'hBEEF;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      lane_q  <= lane_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      vst_q   <= vst_d;
      vbuf_q  <= vbuf_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
      otag_q  <= otag_d;
      oval_q  <= oval_d;
      ovec_q  <= ovec_d;
      ledr_q  <= ledr_d;
      ledg_q  <= ledg_d;
      hex_q   <= hex_d;
    end
  end
  always_ff @(negedge I_CLOCK) begin
    if (we) mem[waddr] <= sdata;
  end
  assign O_Stall      = stall_q;
  assign O_Valid      = valid_q;
  assign O_DestRegIdx = otag_q;
  assign O_DestValue  = oval_q;
  assign O_VecValue   = ovec_q;
  assign O_LEDR       = ledr_q;
  assign O_LEDG       = ledg_q;
  assign O_HexOut     = hex_q;
endmodule

// File: tb/tb_mem_stage_vec.sv
// tb_mem_stage_vec: directed and random checks of mem_stage_vec against an array/register model.
module tb_mem_stage_vec;
  localparam int NL = 4;
  logic I_CLOCK = 0, I_LOCK = 0, I_Valid = 0;
  logic [2:0] I_Op = '0;
  logic [3:0] I_DestRegIdx = '0;
  logic [15:0] I_DestValue = '0, I_MDRValue = '0;
  logic [9:0] I_MARValue = '0;
  logic [63:0] I_VecStoreValue = '0;
  logic s0, v0, s1, v1;
  logic [3:0] t0, t1;
  logic [15:0] d0, d1, h0, h1;
  logic [63:0] w0, w1;
  logic [9:0] lr0, lr1;
  logic [7:0] lg0, lg1;
  logic sel = 0;
  logic o_stall, o_valid;
  logic [3:0] o_tag;
  logic [15:0] o_dval, o_hex;
  logic [63:0] o_vec;
  logic [9:0] o_ledr;
  logic [7:0] o_ledg;
  logic [15:0] m [512];
  logic [9:0] r_ledr;
  logic [7:0] r_ledg;
  logic [15:0] r_hex, r_dv;
  logic [63:0] r_vec;
  int passed = 0, total = 0;

  always #5 I_CLOCK = ~I_CLOCK;

  mem_stage_vec #(.MEM_LATENCY(2)) u0 (
    .I_CLOCK(I_CLOCK), .I_LOCK(I_LOCK), .I_Valid(I_Valid), .I_Op(I_Op),
    .I_DestRegIdx(I_DestRegIdx), .I_DestValue(I_DestValue), .I_MARValue(I_MARValue),
    .I_MDRValue(I_MDRValue), .I_VecStoreValue(I_VecStoreValue),
    .O_Stall(s0), .O_Valid(v0), .O_DestRegIdx(t0), .O_DestValue(d0), .O_VecValue(w0),
    .O_LEDR(lr0), .O_LEDG(lg0), .O_HexOut(h0));
  mem_stage_vec #(.MEM_LATENCY(1)) u1 (
    .I_CLOCK(I_CLOCK), .I_LOCK(I_LOCK), .I_Valid(I_Valid), .I_Op(I_Op),
    .I_DestRegIdx(I_DestRegIdx), .I_DestValue(I_DestValue), .I_MARValue(I_MARValue),
    .I_MDRValue(I_MDRValue), .I_VecStoreValue(I_VecStoreValue),
    .O_Stall(s1), .O_Valid(v1), .O_DestRegIdx(t1), .O_DestValue(d1), .O_VecValue(w1),
    .O_LEDR(lr1), .O_LEDG(lg1), .O_HexOut(h1));

  assign o_stall = sel ? s1 : s0;
  assign o_valid = sel ? v1 : v0;
  assign o_tag   = sel ? t1 : t0;
  assign o_dval  = sel ? d1 : d0;
  assign o_vec   = sel ? w1 : w0;
  assign o_ledr  = sel ? lr1 : lr0;
  assign o_ledg  = sel ? lg1 : lg0;
  assign o_hex   = sel ? h1 : h0;

  task automatic tick();
    @(negedge I_CLOCK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  task automatic model_reset();
    r_ledr = 10'h3FF;
    r_ledg = 8'hFF;
    r_hex  = 16'hBEEF;
    r_dv   = '0;
    r_vec  = '0;
  endtask

  task automatic chk_regs();
    chk("dest_value", o_dval, r_dv);
    chk("vec_value", o_vec, r_vec);
    chk("ledr", o_ledr, r_ledr);
    chk("ledg", o_ledg, r_ledg);
    chk("hex", o_hex, r_hex);
  endtask

  // One request with I_Valid pulsed for its accept edge; inputs are scrambled afterwards.
  task automatic run(input logic [2:0] op, input logic [9:0] mar, input logic [15:0] d, input logic [63:0] vs);
    logic [3:0] tag;
    logic [8:0] w;
    bit isv, ism, mm;
    int lat, k;
    tag = 4'($urandom);
    w   = mar[9:1];
    isv = op == 3'd3 || op == 3'd4;
    ism = op >= 3'd1 && op <= 3'd4;
    mm  = !isv && (mar == 10'h3FC || mar == 10'h3FD || mar == 10'h3FE);
    lat = (isv ? NL : 1) * (sel ? 1 : 2);
    I_Valid = 1; I_Op = op; I_DestRegIdx = tag; I_DestValue = d;
    I_MARValue = mar; I_MDRValue = d; I_VecStoreValue = vs;
    tick();
    I_Valid = 0; I_Op = 3'($urandom); I_DestRegIdx = 4'($urandom); I_DestValue = 16'($urandom);
    I_MARValue = 10'($urandom); I_MDRValue = 16'($urandom); I_VecStoreValue = {$urandom, $urandom};
    if (!ism) begin
      r_dv = d;
      chk("pass_valid", o_valid, 1);
      chk("pass_stall", o_stall, 0);
    end else begin
      chk("stall_on", o_stall, 1);
      k = 0;
      while (!o_valid && k < lat + 4) begin
        tick();
        k++;
      end
      chk("latency", k, lat);
      chk("stall_off", o_stall, 0);
      case (op)
        3'd1: r_dv = !mm ? m[w] : mar == 10'h3FC ? {6'b0, r_ledr} : mar == 10'h3FD ? {8'b0, r_ledg} : r_hex;
        3'd2: if (!mm) m[w] = d;
              else if (mar == 10'h3FC) r_ledr = d[9:0];
              else if (mar == 10'h3FD) r_ledg = d[7:0];
              else r_hex = d;
        3'd3: for (int i = 0; i < NL; i++) r_vec[i*16 +: 16] = m[(int'(w) + i) % 512];
        default: for (int i = 0; i < NL; i++) m[(int'(w) + i) % 512] = vs[i*16 +: 16];
      endcase
    end
    chk("tag", o_tag, tag);
    chk_regs();
    tick();
    chk("valid_pulse", o_valid, 0);
  endtask

  // LDW followed by a pass op held valid throughout the stall.
  task automatic b2b(input logic [9:0] mar);
    int lat, k;
    logic [15:0] pv;
    lat = sel ? 1 : 2;
    I_Valid = 1; I_Op = 3'd1; I_MARValue = mar; I_DestRegIdx = 4'd9;
    tick();
    I_Op = 3'd0; I_MARValue = 10'($urandom); I_DestRegIdx = 4'd3;
    k = 0;
    while (!o_valid && k < lat + 4) begin
      I_DestValue = 16'($urandom);
      tick();
      k++;
    end
    r_dv = m[mar[9:1]];
    chk("b2b_latency", k, lat);
    chk("b2b_ld_value", o_dval, r_dv);
    chk("b2b_ld_tag", o_tag, 9);
    pv = 16'($urandom);
    I_DestValue = pv; I_DestRegIdx = 4'd5;
    tick();
    r_dv = pv;
    chk("b2b_pass_valid", o_valid, 1);
    chk("b2b_pass_value", o_dval, pv);
    chk("b2b_pass_tag", o_tag, 5);
    chk("b2b_pass_stall", o_stall, 0);
    I_Valid = 0;
    tick();
    chk("b2b_valid_pulse", o_valid, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [63:0] vs;
    logic [2:0] op;
    logic [9:0] mar;
    model_reset();
    repeat (2) @(negedge I_CLOCK);
    #1;
    chk("rst_ledr", o_ledr, 10'h3FF);
    chk("rst_ledg", o_ledg, 8'hFF);
    chk("rst_hex", o_hex, 16'hBEEF);
    chk("rst_stall", o_stall, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_tag", o_tag, 0);
    chk("rst_dval", o_dval, 0);
    chk("rst_vec", o_vec, 0);
    I_LOCK = 1;
    tick();
    for (int i = 0; i < 128; i++) run(3'd4, 10'(i * 8), 16'h0, {$urandom, $urandom});
    run(3'd2, 10'h010, 16'h1234, 64'h0);
    run(3'd1, 10'h010, 16'h0, 64'h0);
    chk("ldw_0x010", o_dval, 16'h1234);
    run(3'd4, 10'h020, 16'h0, {16'd4, 16'd3, 16'd2, 16'd1});
    run(3'd3, 10'h020, 16'h0, 64'h0);
    chk("vldw_0x020", o_vec, {16'd4, 16'd3, 16'd2, 16'd1});
    run(3'd1, 10'h024, 16'h0, 64'h0);
    chk("ldw_0x024", o_dval, 16'h0003);
    run(3'd4, 10'h3FC, 16'h0, 64'hDDDD_CCCC_BBBB_AAAA);
    run(3'd1, 10'h000, 16'h0, 64'h0);
    chk("wrap_lane2", o_dval, 16'hCCCC);
    run(3'd1, 10'h002, 16'h0, 64'h0);
    chk("wrap_lane3", o_dval, 16'hDDDD);
    run(3'd2, 10'h3FE, 16'hCAFE, 64'h0);
    chk("mmio_hex", o_hex, 16'hCAFE);
    run(3'd2, 10'h3FC, 16'h0155, 64'h0);
    run(3'd2, 10'h3FC, 16'hFFFF, 64'h0);
    chk("mmio_ledr", o_ledr, 10'h3FF);
    run(3'd1, 10'h3FD, 16'h0, 64'h0);
    chk("mmio_ldw_ledg", o_dval, 16'h00FF);
    run(3'd2, 10'h3FD, 16'h1234, 64'h0);
    run(3'd1, 10'h3FE, 16'h0, 64'h0);
    run(3'd3, 10'h3FC, 16'h0, 64'h0);
    chk("mmio_array_untouched", o_vec[31:16], 16'hBBBB);
    b2b(10'h010);
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      mar = ($urandom_range(0, 3) == 0) ? 10'(10'h3FC + $urandom_range(0, 2)) : 10'($urandom);
      run(op, mar, 16'($urandom), {$urandom, $urandom});
    end
    vs = {$urandom, $urandom};
    I_Valid = 1; I_Op = 3'd4; I_MARValue = 10'h100; I_VecStoreValue = vs;
    tick();
    I_Valid = 0; I_VecStoreValue = ~vs;
    repeat (5) tick();
    #2 I_LOCK = 0;
    #1;
    m[128] = vs[15:0];
    m[129] = vs[31:16];
    model_reset();
    chk("abort_stall", o_stall, 0);
    chk("abort_valid", o_valid, 0);
    chk_regs();
    tick();
    I_LOCK = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_valid", o_valid, 0);
    end
    run(3'd1, 10'h100, 16'h0, 64'h0);
    run(3'd1, 10'h102, 16'h0, 64'h0);
    run(3'd1, 10'h104, 16'h0, 64'h0);
    run(3'd1, 10'h106, 16'h0, 64'h0);
    sel = 1;
    I_LOCK = 0;
    #3;
    model_reset();
    chk("b_rst_valid", o_valid, 0);
    chk_regs();
    tick();
    I_LOCK = 1;
    run(3'd2, 10'h050, 16'hA5A5, 64'h0);
    run(3'd1, 10'h050, 16'h0, 64'h0);
    chk("b_ldw", o_dval, 16'hA5A5);
    vs = {$urandom, $urandom};
    run(3'd4, 10'h060, 16'h0, vs);
    run(3'd3, 10'h060, 16'h0, 64'h0);
    chk("b_vldw", o_vec, vs);
    b2b(10'h050);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_stage_vec.md
Name: mem_stage_vec

Overview:
- Parametrised successor to the pipeline data-memory stage. It sits between execute and writeback.
- Performs scalar and vector (NLANES-wide) word loads/stores against an internal data array with a configurable multi-cycle access latency.
- Keeps memory-mapped LEDR/LEDG/HEX registers.
- Back-pressures execute with a stall while an access is in flight.

Parameters:
DATA_WIDTH, 16, word width in bits
ADDR_WIDTH, 10, byte-address width; array depth = 2^(ADDR_WIDTH-1) words
NLANES, 4, lanes per vector access (>=1)
MEM_LATENCY, 2, clock edges per memory beat (>=1)
ADDR_LEDR, 10'h3FC, LEDR byte address
ADDR_LEDG, 10'h3FD, LEDG byte address
ADDR_HEX, 10'h3FE, HEX byte address

Ports:
I_CLOCK  in  1  clock; all state updates on negedge
I_LOCK  in  1  reset, asynchronous, active-low
I_Valid  in  1  request valid from execute
I_Op  in  3  000 pass, 001 LDW, 010 STW, 011 VLDW, 100 VSTW; others treated as pass
I_DestRegIdx  in  4  destination tag, carried through
I_DestValue  in  DATA_WIDTH  ALU result for pass ops
I_MARValue  in  ADDR_WIDTH  byte address
I_MDRValue  in  DATA_WIDTH  scalar store data
I_VecStoreValue  in  NLANES*DATA_WIDTH  vector store data; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
O_Stall  out  1  busy; execute must hold
O_Valid  out  1  one-cycle result pulse to writeback
O_DestRegIdx  out  4  tag of completing op
O_DestValue  out  DATA_WIDTH  scalar load/pass result
O_VecValue  out  NLANES*DATA_WIDTH  vector load result
O_LEDR  out  10  LEDR register
O_LEDG  out  8  LEDG register
O_HexOut  out  16  HEX register (feeds 7-seg decoders outside)

Behaviour:
- Reset (I_LOCK=0, async) values:
  - O_Valid=0, O_Stall=0.
  - O_DestRegIdx, O_DestValue and O_VecValue = 0.
  - O_LEDR=10'h3FF, O_LEDG=8'hFF, O_HexOut=16'hBEEF.
  - FSM=IDLE, beat and lane counters = 0.
  - Array contents are not reset.
- Reset mid-operation: aborts the access. Store beats already written remain. No O_Valid is produced.
- Word address = I_MARValue >> 1. The LSB is ignored and there is no misalignment fault.
- Accept: on an edge with FSM=IDLE and I_Valid=1. Op, tag, address and data are latched; later input changes are ignored until return to IDLE.
- FSM states are IDLE, BUSY and DONE.
- Pass op:
  - 1-edge latency: O_Valid=1, O_DestValue=I_DestValue at the accept edge.
  - O_Stall stays 0.
- Scalar and vector memory ops: IDLE->BUSY at the accept edge; O_Stall=1 from that edge.
- Beat timing:
  - Each beat lasts MEM_LATENCY edges.
  - Scalar = 1 beat; vector = NLANES beats, lane i at word (base+i) mod depth (wraps at the top of the array).
  - A store beat writes the array at its final edge.
  - A load beat captures the lane at its final edge.
- Completion: after the last beat, BUSY->DONE. At that edge O_Valid=1 for exactly one cycle and O_Stall=0. DONE->IDLE at the next edge, where a new request may be accepted.
- Latency:
  - Total latency from accept to O_Valid = N*MEM_LATENCY edges (N=1 scalar, NLANES vector).
  - Throughput: one request per latency+1 edges.
- O_Valid is also asserted for stores; writeback uses the op to gate register enables.
- MMIO (scalar ops only), matched on I_MARValue[9:0]:
  - STW to ADDR_LEDR/LEDG/HEX updates that register (truncated to register width) with no array write.
  - LDW from these addresses returns the register zero-extended.
  - Timing is the same as a normal scalar access.
- Vector ops never decode MMIO; they always address the array.
- O_VecValue updates only on VLDW completion. O_DestValue updates on pass and LDW completion. Both otherwise hold.
- I_Valid during a stall is ignored; there is no queueing.

Test Plan:
- Reset: LEDR=3FF, LEDG=FF, HEX=BEEF, O_Stall=0, O_Valid=0. Assert I_LOCK=0 mid-VSTW -> FSM IDLE, no O_Valid.
- STW addr 0x010 data 0x1234, then LDW 0x010 (MEM_LATENCY=2):
  - O_Stall high 2 edges per op.
  - LDW O_Valid 2 edges after accept with O_DestValue=0x1234.
- VSTW base 0x020 lanes {1,2,3,4}, then VLDW 0x020 -> O_VecValue={1,2,3,4}, O_Valid 8 edges after accept. Scalar LDW 0x024 -> 0x0003.
- Wrap: VSTW at last word-1 with NLANES=4 -> lanes 2,3 land at words 0,1. Verify by scalar LDW of 0x000 and 0x002.
- MMIO:
  - STW 0x3FE 0xCAFE -> O_HexOut=CAFE.
  - STW 0x3FC 0xFFFF -> O_LEDR=3FF.
  - LDW 0x3FD -> 0x00FF.
  - Array word 0x1FF is unchanged.
- Back-to-back: I_Valid held high with a changing pass op during an LDW stall -> pass value ignored until IDLE. Pass op is accepted 1 edge after LDW O_Valid; MEM_LATENCY=1 sweep repeats this.
